// File: rtl/uart_link_arbiter_if.sv
// Bundle of client request/response signals and UART handshake signals
// for uart_link_arbiter. The master modport is the arbiter side; the slave
// modport is the environment (client FSMs plus UartTx/UartRx instances).
// dbgState mirrors the arbiter FSM state for observation and checkers.
interface uart_link_arbiter_if;
    logic [3:0]  req;
    logic [31:0] reqCmd;
    logic [7:0]  reqRespLen;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [15:0] respData;
    logic        timeout;
    logic        busy;
    logic [7:0]  txData;
    logic        txReq;
    logic        txComplete;
    logic        rxReady;
    logic [7:0]  rxData;
    logic        rxComplete;
    logic [2:0]  dbgState;

    modport master (
        input  req, reqCmd, reqRespLen, txComplete, rxData, rxComplete,
        output grant, done, respData, timeout, busy, txData, txReq, rxReady,
               dbgState
    );

    modport slave (
        output req, reqCmd, reqRespLen, txComplete, rxData, rxComplete,
        input  grant, done, respData, timeout, busy, txData, txReq, rxReady,
               dbgState
    );
endinterface

// File: rtl/uart_link_arbiter.sv
// uart_link_arbiter: shares one UART link to the MCU between four clients.
// Clients post a command byte and a response length (0..2, 3 acts as 2);
// the link is granted round-robin, the command is sent through UartTx, the
// response bytes are collected from UartRx, and a one-cycle done pulse
// returns them to the owning client.
//
// Handshakes: txReq is a level held from grant until the cycle after
// txComplete is sampled. rxReady is raised to ask UartRx for a byte; a byte
// is taken on the first cycle rxComplete is seen while rxReady is high,
// rxReady then drops and the arbiter waits for rxComplete to fall before
// asking for the next byte.
//
// Optional feature macro: ARB_TIMEOUT_EN enables a per-byte watchdog of
// TIMEOUT_TICKS cycles that aborts the transaction and flags timeout.
module uart_link_arbiter #(
    parameter int TIMEOUT_TICKS = 12000
) (
    input  logic                 clock12MHz,
    input  logic                 reset,
    uart_link_arbiter_if.master  link
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_RECV     = 3'd2;
    localparam logic [2:0] ST_RECV_GAP = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // The watchdog counter is 14 bits wide, so the limit must fit.
    if (TIMEOUT_TICKS < 2 || TIMEOUT_TICKS > 16383) begin : g_bad_timeout
        $error("uart_link_arbiter: TIMEOUT_TICKS must be in 2..16383");
    end

    logic [2:0]  state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic [15:0] resp_data_q, resp_data_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_req_q, tx_req_d;
    logic        rx_ready_q, rx_ready_d;

    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  pick_len_raw;
    logic [1:0]  pick_len;

`ifdef ARB_TIMEOUT_EN
    localparam logic [13:0] WD_LAST = 14'(TIMEOUT_TICKS - 1);
    logic [13:0] wd_q, wd_d;
`endif

    // Round-robin pick: first requesting client at or above rr_ptr, wrapping.
    always_comb begin
        logic [1:0] cand;
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!pick_found && link.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_len_raw = link.reqRespLen[{pick_idx, 1'b0} +: 2];
        pick_len     = (pick_len_raw == 2'd3) ? 2'd2 : pick_len_raw;
    end

    // Next-state and next-output logic for the link FSM.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        len_d       = len_q;
        rr_ptr_d    = rr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        grant_d     = grant_q;
        done_d      = 4'b0000;
        resp_data_d = resp_data_q;
        timeout_d   = timeout_q;
        tx_data_d   = tx_data_q;
        tx_req_d    = tx_req_q;
        rx_ready_d  = rx_ready_q;
`ifdef ARB_TIMEOUT_EN
        wd_d        = wd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // The cycle showing a done pulse is never used for a new
                // grant, so a client dropping req on the done edge is not
                // granted again.
                if (pick_found && (done_q == 4'b0000)) begin
                    winner_d    = pick_idx;
                    len_d       = pick_len;
                    tx_data_d   = link.reqCmd[{pick_idx, 3'b000} +: 8];
                    resp_data_d = 16'h0000;
                    grant_d     = 4'b0001 << pick_idx;
                    tx_req_d    = 1'b1;
                    timeout_d   = 1'b0;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (link.txComplete) begin
                    tx_req_d = 1'b0;
                    if (len_q == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        rx_ready_d = 1'b1;
                        byte_cnt_d = 2'd0;
                        state_d    = ST_RECV;
`ifdef ARB_TIMEOUT_EN
                        wd_d       = 14'd0;
`endif
                    end
                end
            end

            ST_RECV: begin
                if (link.rxComplete) begin
                    if (byte_cnt_q == 2'd0) begin
                        resp_data_d[7:0] = link.rxData;
                    end else begin
                        resp_data_d[15:8] = link.rxData;
                    end
                    rx_ready_d = 1'b0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = ST_RECV_GAP;
`ifdef ARB_TIMEOUT_EN
                    wd_d       = 14'd0;
`endif
                end
            end

            ST_RECV_GAP: begin
                if (!link.rxComplete) begin
                    if (byte_cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        rx_ready_d = 1'b1;
                        state_d    = ST_RECV;
                    end
                end
            end

            ST_DONE: begin
                done_d   = 4'b0001 << winner_q;
                rr_ptr_d = winner_q + 2'd1;
                grant_d  = 4'b0000;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        // Watchdog: runs while waiting for response bytes, reloads on each
        // captured byte, and aborts the transaction when it expires.
        if ((state_q == ST_RECV && !link.rxComplete) || state_q == ST_RECV_GAP) begin
            if (wd_q == WD_LAST) begin
                rx_ready_d = 1'b0;
                timeout_d  = 1'b1;
                state_d    = ST_DONE;
            end else begin
                wd_d = wd_q + 14'd1;
            end
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock12MHz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= 2'd0;
            len_q       <= 2'd0;
            rr_ptr_q    <= 2'd0;
            byte_cnt_q  <= 2'd0;
            grant_q     <= 4'b0000;
            done_q      <= 4'b0000;
            resp_data_q <= 16'h0000;
            timeout_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_req_q    <= 1'b0;
            rx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            len_q       <= len_d;
            rr_ptr_q    <= rr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            resp_data_q <= resp_data_d;
            timeout_q   <= timeout_d;
            tx_data_q   <= tx_data_d;
            tx_req_q    <= tx_req_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter register.
    always_ff @(posedge clock12MHz) begin
        if (reset) begin
            wd_q <= 14'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign link.grant    = grant_q;
    assign link.done     = done_q;
    assign link.respData = resp_data_q;
`ifdef ARB_TIMEOUT_EN
    assign link.timeout  = timeout_q;
`else
    assign link.timeout  = 1'b0;
`endif
    assign link.busy     = (state_q != ST_IDLE);
    assign link.txData   = tx_data_q;
    assign link.txReq    = tx_req_q;
    assign link.rxReady  = rx_ready_q;
    assign link.dbgState = state_q;

`ifndef ARB_TIMEOUT_EN
    // Without the watchdog the abort flag register is never set.
    logic unused_timeout;
    assign unused_timeout = timeout_q;
`endif

endmodule
